// File: rtl/wb_retire_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_retire_stage_if
// Description : Bundle for the write-back/retire stage. Carries decode's
//               issue and RAW-query signals, the MEM/WB bundle, and the
//               registered register-file write port.
// Revision    : 1.0  initial release
// ============================================================================
interface wb_retire_stage_if #(
    parameter int DATA  = 32,
    parameter int REG_W = 5
);
    // Decode issue side
    logic             issue_valid;
    logic             issue_writes;
    logic [REG_W-1:0] issue_rd;
    logic             issue_ready;
    // Decode hazard query
    logic [REG_W-1:0] query_rs1;
    logic [REG_W-1:0] query_rs2;
    logic             query_busy;
    // MEM/WB bundle
    logic             mem_valid;
    logic             mem_reg_write;
    logic             mem_wb_sel;
    logic             mem_halt;
    logic [REG_W-1:0] mem_rd;
    logic [DATA-1:0]  mem_alu_result;
    logic [DATA-1:0]  mem_load_data;
    // Register-file write port
    logic             wr_en;
    logic [REG_W-1:0] wr_addr;
    logic [DATA-1:0]  wr_data;

    // Pipeline side (decode + MEM stage + register file)
    modport master (
        output issue_valid, issue_writes, issue_rd,
        output query_rs1, query_rs2,
        output mem_valid, mem_reg_write, mem_wb_sel, mem_halt, mem_rd,
        output mem_alu_result, mem_load_data,
        input  issue_ready, query_busy,
        input  wr_en, wr_addr, wr_data
    );

    // Retire stage side
    modport slave (
        input  issue_valid, issue_writes, issue_rd,
        input  query_rs1, query_rs2,
        input  mem_valid, mem_reg_write, mem_wb_sel, mem_halt, mem_rd,
        input  mem_alu_result, mem_load_data,
        output issue_ready, query_busy,
        output wr_en, wr_addr, wr_data
    );
endinterface
`default_nettype wire

// File: rtl/wb_retire_stage.sv
`default_nettype none
// ============================================================================
// Module      : wb_retire_stage
// Description : Write-back / retire stage. Tracks in-order pending
//               destinations, checks retire order, drives the registered
//               register-file write port, answers RAW queries and drains
//               the pipeline on HALT.
//               Optional macro STAT_COUNTERS_EN enables saturating retire
//               and register-write statistics counters.
// Revision    : 1.0  initial release
// ============================================================================
module wb_retire_stage #(
    parameter int DATA  = 32,
    parameter int REG_W = 5,
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  wire logic             clock_i,
    input  wire logic             rst_ni,
    wb_retire_stage_if.slave      bus,
    output logic                  halted_o,
    output logic                  order_err_o,
    output logic [CNT_W-1:0]      retired_cnt_o,
    output logic [CNT_W-1:0]      regwrite_cnt_o
);
    localparam int PTR_W = $clog2(DEPTH);
    // DEPTH is a power of two, so one extra bit covers 0..DEPTH
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] C_FULL = OCC_W'(DEPTH);

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_DRAIN  = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;

    logic [DEPTH-1:0] ent_writes_q;
    logic [REG_W-1:0] ent_rd_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0] count_q, count_d;
    logic [1:0]       state_q, state_d;

    logic             wr_en_q;
    logic [REG_W-1:0] wr_addr_q;
    logic [DATA-1:0]  wr_data_q;
    logic             order_err_q;

    logic             w_full, w_empty, w_issue_ready;
    logic             w_push, w_pop_req, w_pop, w_underflow, w_mismatch;
    logic             w_wr_en_d;
    logic [DEPTH-1:0] w_ent_valid;
    logic             w_busy;

    assign w_full      = (count_q == C_FULL);
    assign w_empty     = (count_q == '0);
    // Pushes only happen in RUN, which already excludes HALTED
    assign w_push      = bus.issue_valid && w_issue_ready;
    assign w_pop_req   = bus.mem_valid && (state_q != S_HALTED);
    assign w_pop       = w_pop_req && !w_empty;
    assign w_underflow = w_pop_req && w_empty;
    // rd only matters when the head entry actually writes
    assign w_mismatch  = (ent_writes_q[rd_ptr_q] != bus.mem_reg_write) ||
                         (ent_writes_q[rd_ptr_q] && (ent_rd_q[rd_ptr_q] != bus.mem_rd));
    assign w_wr_en_d   = w_pop && bus.mem_reg_write;

    // Occupancy after this cycle's push/pop
    always_comb begin
        count_d = count_q;
        if (w_push && !w_pop)
            count_d = count_q + OCC_W'(1);
        else if (!w_push && w_pop)
            count_d = count_q - OCC_W'(1);
    end

    // RAW query: any live writing entry whose rd matches either source
    always_comb begin
        w_ent_valid = '0;
        w_busy      = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w_ent_valid[i] = ({1'b0, PTR_W'(PTR_W'(i) - rd_ptr_q)} < count_q);
            if (w_ent_valid[i] && ent_writes_q[i] &&
                ((ent_rd_q[i] == bus.query_rs1) || (ent_rd_q[i] == bus.query_rs2)))
                w_busy = 1'b1;
        end
    end

    // Pending-destination FIFO storage and pointers
    always_ff @(posedge clock_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ent_writes_q <= '0;
            for (int i = 0; i < DEPTH; i++)
                ent_rd_q[i] <= '0;
        end else begin
            if (w_push) begin
                ent_writes_q[wr_ptr_q] <= bus.issue_writes;
                ent_rd_q[wr_ptr_q]     <= bus.issue_rd;
                wr_ptr_q               <= wr_ptr_q + PTR_W'(1);
            end
            if (w_pop)
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // Halt FSM state register
    always_ff @(posedge clock_i or negedge rst_ni) begin
        if (!rst_ni)
            state_q <= S_RUN;
        else
            state_q <= state_d;
    end

    // Halt FSM next state: drain outstanding entries after a retired HALT
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN: begin
                if (w_pop && bus.mem_halt)
                    state_d = (count_d == '0) ? S_HALTED : S_DRAIN;
            end
            S_DRAIN: begin
                if (count_d == '0)
                    state_d = S_HALTED;
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_RUN;
        endcase
    end

    // Halt FSM outputs
    always_comb begin
        w_issue_ready = !w_full && (state_q == S_RUN);
        halted_o      = (state_q == S_HALTED);
    end

    // Registered write port and sticky order error
    always_ff @(posedge clock_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            order_err_q <= 1'b0;
        end else begin
            wr_en_q <= w_wr_en_d;
            if (w_pop) begin
                wr_addr_q <= bus.mem_rd;
                wr_data_q <= bus.mem_wb_sel ? bus.mem_alu_result : bus.mem_load_data;
            end
            if (w_underflow || (w_pop && w_mismatch))
                order_err_q <= 1'b1;
        end
    end

`ifdef STAT_COUNTERS_EN
    logic [CNT_W-1:0] retired_cnt_q, regwrite_cnt_q;

    // Saturating statistics: pops and register writes
    always_ff @(posedge clock_i or negedge rst_ni) begin
        if (!rst_ni) begin
            retired_cnt_q  <= '0;
            regwrite_cnt_q <= '0;
        end else begin
            if (w_pop && (retired_cnt_q != '1))
                retired_cnt_q <= retired_cnt_q + CNT_W'(1);
            if (w_wr_en_d && (regwrite_cnt_q != '1))
                regwrite_cnt_q <= regwrite_cnt_q + CNT_W'(1);
        end
    end

    assign retired_cnt_o  = retired_cnt_q;
    assign regwrite_cnt_o = regwrite_cnt_q;
`else
    assign retired_cnt_o  = '0;
    assign regwrite_cnt_o = '0;
`endif

    assign bus.issue_ready = w_issue_ready;
    assign bus.query_busy  = w_busy;
    assign bus.wr_en       = wr_en_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign order_err_o     = order_err_q;
endmodule
`default_nettype wire

// File: tb/tb_wb_retire_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_retire_stage
// Description : Directed self-checking bench for wb_retire_stage.
// Revision    : 1.0  initial release
// ============================================================================
module tb_wb_retire_stage;
    localparam int DATA  = 32;
    localparam int REG_W = 5;
    localparam int DEPTH = 4;
    localparam int CNT_W = 32;
`ifdef STAT_COUNTERS_EN
    localparam int STAT = 1;
`else
    localparam int STAT = 0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             halted;
    logic             order_err;
    logic [CNT_W-1:0] retired_cnt;
    logic [CNT_W-1:0] regwrite_cnt;

    int errors = 0;
    int checks = 0;

    wb_retire_stage_if #(.DATA(DATA), .REG_W(REG_W)) bus ();

    wb_retire_stage #(.DATA(DATA), .REG_W(REG_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock_i        (clk),
        .rst_ni         (rst_n),
        .bus            (bus),
        .halted_o       (halted),
        .order_err_o    (order_err),
        .retired_cnt_o  (retired_cnt),
        .regwrite_cnt_o (regwrite_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.issue_valid    = 1'b0;
        bus.issue_writes   = 1'b0;
        bus.issue_rd       = '0;
        bus.query_rs1      = '0;
        bus.query_rs2      = '0;
        bus.mem_valid      = 1'b0;
        bus.mem_reg_write  = 1'b0;
        bus.mem_wb_sel     = 1'b0;
        bus.mem_halt       = 1'b0;
        bus.mem_rd         = '0;
        bus.mem_alu_result = '0;
        bus.mem_load_data  = '0;
    endtask

    task automatic push(input int writes, input int rd);
        bus.issue_valid  = 1'b1;
        bus.issue_writes = (writes != 0);
        bus.issue_rd     = REG_W'(rd);
        cyc();
        bus.issue_valid  = 1'b0;
    endtask

    task automatic retire(input int rw, input int rd, input int sel,
                          input logic [31:0] alu, input logic [31:0] load, input int halt);
        bus.mem_valid      = 1'b1;
        bus.mem_reg_write  = (rw != 0);
        bus.mem_rd         = REG_W'(rd);
        bus.mem_wb_sel     = (sel != 0);
        bus.mem_alu_result = alu;
        bus.mem_load_data  = load;
        bus.mem_halt       = (halt != 0);
        cyc();
        bus.mem_valid      = 1'b0;
        bus.mem_halt       = 1'b0;
    endtask

    task automatic query(input int rs1, input int rs2);
        bus.query_rs1 = REG_W'(rs1);
        bus.query_rs2 = REG_W'(rs2);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        // ---------------- reset values ----------------
        cyc();
        cyc();
        chk("rst_issue_ready", 32'(bus.issue_ready), 1);
        chk("rst_query_busy",  32'(bus.query_busy), 0);
        chk("rst_wr_en",       32'(bus.wr_en), 0);
        chk("rst_wr_addr",     32'(bus.wr_addr), 0);
        chk("rst_wr_data",     bus.wr_data, 0);
        chk("rst_halted",      32'(halted), 0);
        chk("rst_order_err",   32'(order_err), 0);
        chk("rst_retired",     retired_cnt, 0);
        chk("rst_regwrite",    regwrite_cnt, 0);
        rst_n = 1'b1;
        cyc();

        // ---------------- basic push / query / retire ----------------
        push(1, 3);
        query(3, 0);
        chk("busy_rd3", 32'(bus.query_busy), 1);
        query(5, 6);
        chk("busy_other", 32'(bus.query_busy), 0);
        query(3, 0);
        retire(1, 3, 1, 32'h0000_00AA, 32'h0000_0055, 0);
        chk("a_wr_en",   32'(bus.wr_en), 1);
        chk("a_wr_addr", 32'(bus.wr_addr), 3);
        chk("a_wr_data", bus.wr_data, 32'h0000_00AA);
        chk("a_busy_after", 32'(bus.query_busy), 0);
        cyc();
        chk("a_wr_en_pulse", 32'(bus.wr_en), 0);

        // ---------------- fill, full, same-cycle push/pop ----------------
        push(1, 10);
        push(1, 11);
        push(1, 12);
        chk("b_ready_3", 32'(bus.issue_ready), 1);
        push(1, 13);
        chk("b_ready_full", 32'(bus.issue_ready), 0);
        push(1, 20);
        query(20, 0);
        chk("b_full_drop", 32'(bus.query_busy), 0);
        query(0, 12);
        chk("b_busy_rs2", 32'(bus.query_busy), 1);
        retire(1, 10, 1, 32'h10, 32'h0, 0);
        retire(1, 11, 1, 32'h11, 32'h0, 0);
        bus.issue_valid   = 1'b1;
        bus.issue_writes  = 1'b1;
        bus.issue_rd      = 5'd14;
        bus.mem_valid     = 1'b1;
        bus.mem_reg_write = 1'b1;
        bus.mem_rd        = 5'd12;
        bus.mem_wb_sel    = 1'b1;
        bus.mem_alu_result = 32'h12;
        query(12, 0);
        chk("b_busy_popping", 32'(bus.query_busy), 1);
        cyc();
        bus.issue_valid = 1'b0;
        bus.mem_valid   = 1'b0;
        chk("b_pp_wr_addr", 32'(bus.wr_addr), 12);
        query(12, 0);
        chk("b_busy_popped", 32'(bus.query_busy), 0);
        query(14, 0);
        chk("b_busy_pushed", 32'(bus.query_busy), 1);
        chk("b_ready_cnt2", 32'(bus.issue_ready), 1);
        push(1, 15);
        chk("b_ready_cnt3", 32'(bus.issue_ready), 1);
        push(1, 16);
        chk("b_ready_cnt4", 32'(bus.issue_ready), 0);
        for (int r = 13; r <= 16; r++)
            retire(1, r, 1, 32'(r), 32'h0, 0);
        query(16, 13);
        chk("b_drained_busy", 32'(bus.query_busy), 0);
        chk("b_order_ok", 32'(order_err), 0);

        // ---------------- load write-back and order mismatch ----------------
        push(1, 7);
        push(1, 7);
        retire(1, 7, 0, 32'hDEAD_BEEF, 32'h1234_5678, 0);
        chk("c_load_en",   32'(bus.wr_en), 1);
        chk("c_load_addr", 32'(bus.wr_addr), 7);
        chk("c_load_data", bus.wr_data, 32'h1234_5678);
        chk("c_no_err",    32'(order_err), 0);
        retire(1, 9, 1, 32'h0000_0099, 32'h0, 0);
        chk("c_mismatch_err",  32'(order_err), 1);
        chk("c_mismatch_en",   32'(bus.wr_en), 1);
        chk("c_mismatch_addr", 32'(bus.wr_addr), 9);
        cyc();
        cyc();
        chk("c_err_sticky", 32'(order_err), 1);

        // ---------------- statistics ----------------
        do_reset();
        chk("d_cnt_reset", retired_cnt, 0);
        chk("d_err_reset", 32'(order_err), 0);
        push(1, 5);
        push(0, 0);
        push(1, 6);
        retire(1, 5, 1, 32'h5, 32'h0, 0);
        retire(0, 0, 1, 32'h0, 32'h0, 0);
        chk("d_nowrite_en", 32'(bus.wr_en), 0);
        retire(1, 6, 1, 32'h6, 32'h0, 0);
        chk("d_retired",  retired_cnt, 32'(3 * STAT));
        chk("d_regwrite", regwrite_cnt, 32'(2 * STAT));
        chk("d_no_err",   32'(order_err), 0);

        // ---------------- halt drain ----------------
        push(1, 20);
        push(1, 21);
        push(1, 22);
        retire(1, 20, 1, 32'h20, 32'h0, 1);
        chk("e_drain_ready",  32'(bus.issue_ready), 0);
        chk("e_drain_halted", 32'(halted), 0);
        push(1, 25);
        retire(1, 21, 1, 32'h21, 32'h0, 0);
        chk("e_drain1_halted", 32'(halted), 0);
        retire(1, 22, 1, 32'h22, 32'h0, 0);
        chk("e_halted",      32'(halted), 1);
        chk("e_last_wr_en",  32'(bus.wr_en), 1);
        chk("e_last_addr",   32'(bus.wr_addr), 22);
        query(25, 0);
        chk("e_drain_push_blocked", 32'(bus.query_busy), 0);
        retire(1, 23, 1, 32'h23, 32'h0, 0);
        chk("e_ignored_wr_en", 32'(bus.wr_en), 0);
        chk("e_ignored_err",   32'(order_err), 0);
        chk("e_halted_ready",  32'(bus.issue_ready), 0);
        chk("e_retired",  retired_cnt, 32'(6 * STAT));
        chk("e_regwrite", regwrite_cnt, 32'(5 * STAT));

        // ---------------- asynchronous reset mid-drain ----------------
        do_reset();
        chk("f_halted_cleared", 32'(halted), 0);
        push(1, 8);
        push(1, 9);
        retire(1, 8, 1, 32'h8, 32'h0, 1);
        query(9, 0);
        chk("f_drain_busy",  32'(bus.query_busy), 1);
        chk("f_drain_ready", 32'(bus.issue_ready), 0);
        rst_n = 1'b0;
        #1;
        chk("f_async_busy",  32'(bus.query_busy), 0);
        chk("f_async_ready", 32'(bus.issue_ready), 1);
        rst_n = 1'b1;
        cyc();

        // ---------------- retire on empty FIFO ----------------
        retire(1, 4, 1, 32'h44, 32'h0, 0);
        chk("g_underflow_err", 32'(order_err), 1);
        chk("g_underflow_en",  32'(bus.wr_en), 0);
        chk("g_underflow_cnt", retired_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/wb_retire_stage.md
# wb_retire_stage

Write-back and retire stage of the 5-stage MIPS pipeline; the writing end of the decode stage's register-file and hazard interfaces. Decode pushes each issued instruction's destination into an in-order pending-destination FIFO. This block retires MEM/WB bundles against that FIFO, drives the registered register-file write port, and answers decode's combinational RAW-hazard queries. It also owns halt draining and retire statistics.

## Interface
- DATA, 32, data/register width
- REG_W, 5, register index width
- DEPTH, 4, pending-destination FIFO entries (power of 2, ≥2)
- CNT_W, 32, statistic counter width
- clock  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- issue_valid  in  1  decode issues an instruction this cycle
- issue_writes  in  1  issued instruction writes a register (regWrite)
- issue_rd  in  REG_W  destination of issued instruction
- issue_ready  out  1  FIFO can accept an issue
- query_rs1, query_rs2  in  REG_W  decode source operands
- query_busy  out  1  a source matches a pending writing destination
- mem_valid  in  1  MEM/WB bundle valid
- mem_reg_write  in  1  bundle writes a register
- mem_wb_sel  in  1  1 = ALU result, 0 = load data
- mem_halt  in  1  bundle is a HALT
- mem_rd  in  REG_W  bundle destination
- mem_alu_result, mem_load_data  in  DATA  write-back candidates
- wr_en  out  1  register-file write enable
- wr_addr  out  REG_W  register-file write index
- wr_data  out  DATA  register-file write data
- halted  out  1  pipeline fully drained after HALT
- order_err  out  1  sticky retire-order/underflow error
- retired_cnt, regwrite_cnt  out  CNT_W  statistics

## Operation
- FIFO entry = {writes, rd}. Push on issue_valid && issue_ready && state != HALTED. Pop on mem_valid && state != HALTED && FIFO non-empty.
- issue_ready = !full && state == RUN. This is a registered-state function only; there is no push/pop bypass when full.
- query_busy: purely combinational. OR over valid entries with writes=1 and rd equal to query_rs1 or query_rs2. Register 0 is an ordinary register.
- Retire check: popped entry must have writes == mem_reg_write and rd == mem_rd (rd compared only when writes=1). A mismatch sets order_err; the write proceeds anyway.
- Pop attempted on empty FIFO: order_err set, no pop, no write, not counted.
- Write port (registered): wr_en ← pop && mem_reg_write. wr_addr ← mem_rd. wr_data ← mem_wb_sel ? mem_alu_result : mem_load_data.
- Halt FSM, states RUN, DRAIN, HALTED:
  - RUN → DRAIN when a retiring bundle has mem_halt=1 and FIFO occupancy after the pop is non-zero.
  - RUN → HALTED directly when occupancy after the pop is zero.
  - DRAIN → HALTED when occupancy reaches zero. DRAIN still retires; pushes are blocked.
  - HALTED is terminal until reset. mem_valid is ignored and wr_en stays 0.
- Pointers wrap modulo DEPTH. Occupancy is tracked with a DEPTH+1-range counter; full = (count == DEPTH).

## Timing
- Reset values: FIFO empty, state RUN, wr_en=0, wr_addr=0, wr_data=0, halted=0, order_err=0, counters=0. issue_ready=1 and query_busy=0 follow from the empty FIFO.
- Reset asserted mid-drain discards all entries immediately and asynchronously.
- Write port latency: 1 cycle from the retiring mem_valid edge. Decode sees the write on the following clock.
- Push and pop in the same cycle: occupancy unchanged. A query in that cycle still sees the popped entry.
- query_busy reflects FIFO contents at the start of the cycle. A push is visible to queries from the next cycle.
- halted rises in the cycle after the transition edge into HALTED.

## Configuration
- STAT_COUNTERS_EN defined:
  - retired_cnt increments per successful pop.
  - regwrite_cnt increments per wr_en assertion.
  - Both saturate at all-ones.
- Undefined: both outputs are constant 0 and no counter flops exist.

## Test plan
- Reset, then push rd=3 (writes=1), query rs1=3 → query_busy=1. Retire mem_rd=3, mem_wb_sel=1, alu=0x0000_00AA → next cycle wr_en=1, wr_addr=3, wr_data=0xAA; query_busy=0.
- Push 4 writing entries without retiring → issue_ready=0 after the 4th. Issue attempted while full → not stored. Simultaneous pop and push when count=2 → count stays 2.
- Retire with mem_wb_sel=0, load=0x1234_5678, rd=7 → wr_data=0x12345678. Retire with mem_rd=9 vs head rd=7 → order_err=1 and stays 1.
- HALT retired with 2 entries pending → DRAIN and issue_ready=0. Two further retires → halted=1. Later mem_valid → wr_en=0.
- mem_valid on empty FIFO → order_err=1, no write. With STAT_COUNTERS_EN, 3 good retires (2 writing) → retired_cnt=3, regwrite_cnt=2. Without the macro → both 0.
